// File: rtl/apb_slave_regbank.sv
// APB responder: DEPTH-1 read/write words plus a read-only status word holding
// completed-write and aborted-transfer counts, with programmable wait states.
//
// state  | meaning
// IDLE   | no transfer in flight; a setup phase (psel && !penable) starts one
// ACCESS | access phase; wcnt counts wait states until pready, or !psel aborts
module apb_slave_regbank #(
  parameter int          DEPTH       = 16,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] RESET_VAL   = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] STAT_IDX = AW'(DEPTH - 1);
  localparam logic [3:0]    WAIT_TC  = 4'(WAIT_CYCLES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state_q, state_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic [31:0]   regs [DEPTH-1];
  logic [15:0]   wr_cnt_q;
  logic [15:0]   abort_cnt_q;
  logic [AW-1:0] idx;
  logic          unmapped;
  logic          commit;
  logic          abort;
  logic [31:0]   status;

  assign idx      = paddr[AW+1:2];
  assign unmapped = |paddr[31:AW+2];
  assign status   = {abort_cnt_q, wr_cnt_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    pready  = 1'b0;
    commit  = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        // psel && penable here is a protocol violation and is simply ignored
        if (psel && !penable) begin
          state_d = ACCESS;
          wcnt_d  = 4'd0;
        end
      end
      ACCESS: begin
        if (!psel) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (penable) begin
          if (wcnt_q == WAIT_TC) begin
            pready  = 1'b1;
            state_d = IDLE;
            commit  = pwrite && !unmapped && (idx != STAT_IDX);
          end else begin
            wcnt_d = wcnt_q + 4'd1;
          end
        end
      end
    endcase
  end

  // prdata is driven only in the completing read cycle so the master can OR slaves
  always_comb begin
    prdata = 32'h0;
    if (pready && !pwrite && !unmapped) begin
      if (idx == STAT_IDX) prdata = status;
      else                 prdata = regs[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH - 1; i++) regs[i] <= RESET_VAL;
    end else if (commit) begin
      regs[idx] <= pwdata;
    end
  end

  // write count wraps, abort count saturates; commit and abort are exclusive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q    <= 16'h0;
      abort_cnt_q <= 16'h0;
    end else begin
      if (commit) wr_cnt_q <= wr_cnt_q + 16'h1;
      if (abort && abort_cnt_q != 16'hFFFF) abort_cnt_q <= abort_cnt_q + 16'h1;
    end
  end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Bench for apb_slave_regbank: two instances (0 and 3 wait states) driven by
// directed and random APB transfers, checked against a word-array model.
module tb_apb_slave_regbank;

  localparam int          NW = 16;
  localparam logic [31:0] RV0 = 32'h0000_0000;
  localparam logic [31:0] RV1 = 32'h5A5A_C3C3;
  int W [2] = '{0, 3};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel [2];
  logic        penable [2];
  logic        pwrite [2];
  logic [31:0] paddr [2];
  logic [31:0] pwdata [2];
  logic [31:0] prdata [2];
  logic        pready [2];

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  logic [31:0] mem [2][NW];
  logic [15:0] mwr [2];
  logic [15:0] mab [2];

  always #5 clk = ~clk;

  apb_slave_regbank #(.DEPTH(NW), .WAIT_CYCLES(0), .RESET_VAL(RV0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
    .prdata(prdata[0]), .pready(pready[0]));

  apb_slave_regbank #(.DEPTH(NW), .WAIT_CYCLES(3), .RESET_VAL(RV1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
    .prdata(prdata[1]), .pready(pready[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NW; i++) mem[d][i] = (d == 0) ? RV0 : RV1;
      mwr[d] = 16'h0;
      mab[d] = 16'h0;
    end
  endtask

  function automatic logic [31:0] model_read(input int d, input logic [31:0] a);
    if (a[31:6] != 26'd0) return 32'h0;
    if (a[5:2] == 4'(NW - 1)) return {mab[d], mwr[d]};
    return mem[d][a[5:2]];
  endfunction

  // abort_after = k drops psel in what would have been access cycle k (-1: none)
  task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                      input logic [31:0] data, input int abort_after,
                      output logic [31:0] rd);
    logic [31:0] exp_rd;
    bit exp_rdy;
    rd = 32'h0;
    @(posedge clk); #1;
    for (int o = 0; o < 2; o++) begin
      psel[o] = 1'b0;
      penable[o] = 1'b0;
    end
    psel[d] = 1'b1; pwrite[d] = wr; paddr[d] = a; pwdata[d] = data;
    @(negedge clk);
    chk($sformatf("d%0d setup_rdy a=%h", d, a), {31'd0, pready[d]}, 32'h0);
    for (int k = 0; k <= W[d]; k++) begin
      @(posedge clk); #1;
      if (k == abort_after) begin
        psel[d] = 1'b0;
        penable[d] = 1'b0;
        @(negedge clk);
        chk($sformatf("d%0d abort_rdy a=%h", d, a), {31'd0, pready[d]}, 32'h0);
        if (mab[d] != 16'hFFFF) mab[d]++;
        return;
      end
      penable[d] = 1'b1;
      @(negedge clk);
      exp_rdy = (k == W[d]);
      exp_rd = (exp_rdy && !wr) ? model_read(d, a) : 32'h0;
      chk($sformatf("d%0d rdy k=%0d a=%h", d, k, a), {31'd0, pready[d]}, {31'd0, exp_rdy});
      chk($sformatf("d%0d prdata k=%0d a=%h", d, k, a), prdata[d], exp_rd);
      rd = prdata[d];
    end
    if (wr && a[31:6] == 26'd0 && a[5:2] != 4'(NW - 1)) begin
      mem[d][a[5:2]] = data;
      mwr[d]++;
    end
  endtask

  task automatic idle_all();
    @(posedge clk); #1;
    for (int o = 0; o < 2; o++) begin
      psel[o] = 1'b0;
      penable[o] = 1'b0;
    end
  endtask

  logic [31:0] rd;
  logic [31:0] ra;
  int          rdut, rab;
  bit          rwr;

  initial begin
    for (int o = 0; o < 2; o++) begin
      psel[o] = 1'b0; penable[o] = 1'b0; pwrite[o] = 1'b0;
      paddr[o] = 32'h0; pwdata[o] = 32'h0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rdy0", {31'd0, pready[0]}, 32'h0);
    chk("reset_rdy1", {31'd0, pready[1]}, 32'h0);
    chk("reset_prdata0", prdata[0], 32'h0);
    rst_n = 1'b1;

    // reset values
    xfer(0, 1'b0, 32'h0C, 32'h0, -1, rd);
    chk("reset_word", rd, RV0);
    xfer(0, 1'b0, 32'h3C, 32'h0, -1, rd);
    chk("reset_status", rd, 32'h0);
    xfer(1, 1'b0, 32'h0C, 32'h0, -1, rd);
    chk("reset_word_d1", rd, RV1);

    // zero-wait write/read
    xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, -1, rd);
    xfer(0, 1'b0, 32'h08, 32'h0, -1, rd);
    chk("wr_rd_0x08", rd, 32'hDEADBEEF);
    xfer(0, 1'b0, 32'h3C, 32'h0, -1, rd);
    chk("status_one_write", rd, 32'h0000_0001);

    // three wait states
    xfer(1, 1'b0, 32'h04, 32'h0, -1, rd);
    chk("wait3_rd", rd, RV1);

    // back-to-back, no idle gap
    xfer(0, 1'b1, 32'h00, 32'h11111111, -1, rd);
    xfer(0, 1'b1, 32'h04, 32'h22222222, -1, rd);
    xfer(0, 1'b0, 32'h00, 32'h0, -1, rd);
    chk("b2b_rd_0x00", rd, 32'h11111111);
    xfer(0, 1'b0, 32'h3C, 32'h0, -1, rd);
    chk("b2b_status", rd, 32'h0000_0003);

    // abort after one access cycle
    xfer(1, 1'b1, 32'h10, 32'hAAAA5555, 1, rd);
    xfer(1, 1'b0, 32'h10, 32'h0, -1, rd);
    chk("abort_old_val", rd, RV1);
    xfer(1, 1'b0, 32'h3C, 32'h0, -1, rd);
    chk("abort_status", rd, 32'h0001_0000);

    // protection and unmapped
    xfer(0, 1'b1, 32'h3C, 32'hFFFFFFFF, -1, rd);
    xfer(0, 1'b1, 32'h100, 32'h12345678, -1, rd);
    xfer(0, 1'b0, 32'h100, 32'h0, -1, rd);
    chk("unmapped_rd", rd, 32'h0);
    xfer(0, 1'b0, 32'h00, 32'h0, -1, rd);
    chk("unmapped_no_alias", rd, 32'h11111111);
    xfer(0, 1'b0, 32'h3C, 32'h0, -1, rd);
    chk("protect_status", rd, 32'h0000_0003);

    // enable without setup while idle is ignored
    @(posedge clk); #1;
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b0; paddr[0] = 32'h08;
    @(negedge clk);
    chk("violation_rdy_a", {31'd0, pready[0]}, 32'h0);
    @(negedge clk);
    chk("violation_rdy_b", {31'd0, pready[0]}, 32'h0);
    chk("violation_prdata", prdata[0], 32'h0);
    idle_all();

    // random traffic against the model
    for (int n = 0; n < 80; n++) begin
      rdut = int'($urandom_range(0, 1));
      rwr  = 1'($urandom);
      if ($urandom_range(0, 7) == 0) ra = $urandom | 32'h40;
      else ra = {26'd0, 4'($urandom), 2'($urandom)};
      rab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, W[rdut])) : -1;
      xfer(rdut, rwr, ra, $urandom, rab, rd);
      if ($urandom_range(0, 3) == 0) idle_all();
    end
    xfer(0, 1'b0, 32'h3C, 32'h0, -1, rd);
    xfer(1, 1'b0, 32'h3C, 32'h0, -1, rd);

    // reset during the pready cycle of a write
    @(posedge clk); #1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'h14; pwdata[1] = 32'h7777_0000;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_pre_rdy", {31'd0, pready[1]}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_rdy_drop", {31'd0, pready[1]}, 32'h0);
    chk("midrst_prdata", prdata[1], 32'h0);
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    xfer(1, 1'b0, 32'h14, 32'h0, -1, rd);
    chk("midrst_lost_write", rd, RV1);
    xfer(1, 1'b0, 32'h3C, 32'h0, -1, rd);
    chk("midrst_status", rd, 32'h0);
    idle_all();
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
